// File: rtl/csr_pkg.sv
// Shared definitions for the CSR read-modify-write unit: op encodings, counter
// addresses, decode constants and FSM states.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_RD = 2'b00,
        CSR_OP_RW = 2'b01,
        CSR_OP_RS = 2'b10,
        CSR_OP_RC = 2'b11
    } csrOp_e;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StResp
    } csrState_e;

    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam logic [3:0] CSR_WINDOW_PAGE = 4'h3;
    localparam logic [1:0] CSR_RO_PREFIX   = 2'b11;

    // RS/RC with an x0 / zero-immediate source are pure reads.
    function automatic logic opWrites(csrOp_e op, logic srcZero);
        unique case (op)
            CSR_OP_RD: return 1'b0;
            CSR_OP_RW: return 1'b1;
            default:   return !srcZero;
        endcase
    endfunction

endpackage

// File: rtl/csr_rmw_unit_if.sv
// Request/response port between the execute stage (master) and the CSR unit (slave).
interface csr_rmw_unit_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 12
) ();

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              req_src_zero;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_illegal;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_src_zero,
        input  req_ready, rsp_valid, rsp_rdata, rsp_illegal
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_src_zero,
        output req_ready, rsp_valid, rsp_rdata, rsp_illegal
    );

endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half write; a write replaces that cycle's increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (wr_lo) begin
            count[31:0] <= wdata;
        end else if (wr_hi) begin
            count[63:32] <= wdata;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_rmw_unit.sv
// Atomic CSRRW/CSRRS/CSRRC unit with a block-RAM CSR window and optional
// mcycle/minstret counters (enabled by defining CSR_COUNTERS_EN).
module csr_rmw_unit
    import csr_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           instret_inc,
    csr_rmw_unit_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    csrState_e         state;
    logic              readyQ;
    logic              rspValidQ;
    logic              rspIllegalQ;
    logic [XLEN-1:0]   rspRdataQ;

    csrOp_e            opQ;
    logic [ADDR_W-1:0] addrQ;
    logic [XLEN-1:0]   wdataQ;
    logic              srcZeroQ;

    logic [XLEN-1:0]   mem [DEPTH];
    logic [XLEN-1:0]   memRdata;

    logic              storageHit;
    logic              counterHit;
    logic              readOnly;
    logic              writes;
    logic              legal;
    logic              doWrite;
    logic [31:0]       cntHalf;
    logic [XLEN-1:0]   oldVal;
    logic [XLEN-1:0]   newVal;

    // Write and accept are in different states, so the read port never sees a collision.
    always_ff @(posedge clk) begin
        if (doWrite && storageHit) begin
            mem[addrQ[DEPTH_LOG2-1:0]] <= newVal;
        end
        if (state == StIdle && bus.req_valid) begin
            memRdata <= mem[bus.req_addr[DEPTH_LOG2-1:0]];
        end
    end

    assign storageHit = (addrQ[11:8] == CSR_WINDOW_PAGE) && (32'(addrQ[7:0]) < DEPTH);
    assign readOnly   = (addrQ[11:10] == CSR_RO_PREFIX);
    assign writes     = opWrites(opQ, srcZeroQ);
    assign legal      = (storageHit || counterHit) && !(readOnly && writes);
    assign doWrite    = (state == StRead) && legal && writes && !reset;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [63:0] cntSel;
    logic        selHi;
    logic        selInstret;

    assign counterHit = addrQ inside {CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
                                      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH};
    assign selHi      = addrQ[7];
    assign selInstret = addrQ[1];
    assign cntSel     = selInstret ? minstret : mcycle;
    assign cntHalf    = selHi ? cntSel[63:32] : cntSel[31:0];

    // Only the B-page can reach doWrite; C-page writes decode illegal.
    csr_counter64 u_mcycle (
        .clk   (clk),
        .reset (reset),
        .inc   (1'b1),
        .wr_lo (doWrite && counterHit && !selInstret && !selHi),
        .wr_hi (doWrite && counterHit && !selInstret && selHi),
        .wdata (newVal[31:0]),
        .count (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .reset (reset),
        .inc   (instret_inc),
        .wr_lo (doWrite && counterHit && selInstret && !selHi),
        .wr_hi (doWrite && counterHit && selInstret && selHi),
        .wdata (newVal[31:0]),
        .count (minstret)
    );
`else
    logic unusedInstret;
    assign unusedInstret = instret_inc;
    assign counterHit    = 1'b0;
    assign cntHalf       = '0;
`endif

    always_comb begin
        oldVal = '0;
        if (storageHit) begin
            oldVal = memRdata;
        end else if (counterHit) begin
            oldVal = XLEN'(cntHalf);
        end
    end

    always_comb begin
        newVal = oldVal;
        unique case (opQ)
            CSR_OP_RD: newVal = oldVal;
            CSR_OP_RW: newVal = wdataQ;
            CSR_OP_RS: newVal = oldVal | wdataQ;
            CSR_OP_RC: newVal = oldVal & ~wdataQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            readyQ      <= 1'b1;
            rspValidQ   <= 1'b0;
            rspRdataQ   <= '0;
            rspIllegalQ <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.req_valid) begin
                        state    <= StRead;
                        readyQ   <= 1'b0;
                        opQ      <= csrOp_e'(bus.req_op);
                        addrQ    <= bus.req_addr;
                        wdataQ   <= bus.req_wdata;
                        srcZeroQ <= bus.req_src_zero;
                    end
                end
                StRead: begin
                    state       <= StResp;
                    rspValidQ   <= 1'b1;
                    rspRdataQ   <= legal ? oldVal : '0;
                    rspIllegalQ <= !legal;
                end
                StResp: begin
                    state     <= StIdle;
                    rspValidQ <= 1'b0;
                    readyQ    <= 1'b1;
                end
                default: begin
                    state  <= StIdle;
                    readyQ <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready   = readyQ;
    assign bus.rsp_valid   = rspValidQ;
    assign bus.rsp_rdata   = rspRdataQ;
    assign bus.rsp_illegal = rspIllegalQ;

endmodule
